sram_sample_streamer: RTL and testbench

- Parametrised SRAM audio playback engine. On each sample tick it fetches NUM_CH consecutive words from a read-only SRAM region [start_addr..end_addr] and presents them atomically as one frame to the audio codec interface.
- Successor to the fixed two-word left/right reader. Adds generic channel count, width and SRAM wait states, plus start/stop control, loop mode, done pulse and overrun detection.

---
 rtl/sram_sample_streamer_pkg.sv | 29 ++
 rtl/sram_sample_streamer_tick_sync.sv | 24 ++
 rtl/sram_sample_streamer.sv | 178 +++++++++++++++++
 tb/tb_sram_sample_streamer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sample_streamer_pkg.sv
// sample_streamer_pkg: shared types and constants for the SRAM sample streamer.
//   state_t      - fetch FSM states
//   SRAM_*_C     - fixed SRAM strobe levels (active-low pins)
//   wait_cnt_w() - width of the wait-state counter for a given WAIT_CYC
package sample_streamer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ADDR,
    WAIT,
    CAPTURE,
    COMMIT
  } state_t;

  localparam int   SRAM_DQ_W   = 16;
  localparam logic SRAM_CE_N_C = 1'b0;  // chip always selected
  localparam logic SRAM_WE_N_C = 1'b1;  // read-only region, never write
  localparam logic SRAM_UB_N_C = 1'b0;  // both byte lanes enabled
  localparam logic SRAM_LB_N_C = 1'b0;
  localparam logic SRAM_OE_ON  = 1'b0;
  localparam logic SRAM_OE_OFF = 1'b1;

  // Counter runs 0..wait_cyc-1; keep at least one bit so WAIT_CYC=0/1 still elaborate.
  function automatic int wait_cnt_w(input int wait_cyc);
    return (wait_cyc < 2) ? 1 : $clog2(wait_cyc);
  endfunction

endpackage

// File: rtl/sram_sample_streamer_tick_sync.sv
// tick_sync: brings the asynchronous AUD_CLK level into the CLK domain and
// emits a one-cycle pulse on its rising edge.
//   CLK, RESET - system clock, async active-high reset
//   async_in   - asynchronous level
//   tick       - one-cycle pulse, visible after the 2nd CLK edge following
//                the input edge and consumed by downstream logic on the 3rd
module tick_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic async_in,
  output logic tick
);

  // [0],[1] form the synchroniser; [2] is the previous synchronised level.
  logic [2:0] sync_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], async_in};
  end

  assign tick = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/sram_sample_streamer.sv
// sram_sample_streamer: on every AUD_CLK tick, reads NUM_CH consecutive words
// from the SRAM region [start_addr..end_addr] and publishes them as one frame.
//   CLK, RESET           - system clock, async active-high reset
//   AUD_CLK              - sample-rate level from the codec domain
//   start/stop           - one-cycle control pulses (stop wins)
//   loop_en              - wrap to start_addr after end_addr
//   start_addr/end_addr  - region bounds, latched on start
//   SRAM_*               - async SRAM port; SRAM_DQ is only ever read
//   sample_out           - frame, channel k at [k*DATA_W +: DATA_W]
//   sample_valid         - pulses when sample_out updates
//   busy/done/overrun    - status
// Build option: define ZERO_ON_IDLE_EN to force sample_out to silence on
// every return to IDLE.
module sram_sample_streamer
  import sample_streamer_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     AUD_CLK,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  inout  wire  [SRAM_DQ_W-1:0]     SRAM_DQ,
  output logic [ADDR_W-1:0]        SRAM_ADDR,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N,
  output logic [NUM_CH*DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam int WAIT_CNT_W = wait_cnt_w(WAIT_CYC);
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                         state;
  logic [ADDR_W-1:0]              cur_addr, start_q, end_q;
  logic [CH_W-1:0]                ch;
  logic [WAIT_CNT_W-1:0]          wcnt;
  logic                           end_flag;
  logic [NUM_CH-1:0][DATA_W-1:0]  stage;
  logic                           tick;
  logic                           last_ch, at_end;
`ifdef ZERO_ON_IDLE_EN
  logic                           zero_pend;
`endif

  tick_sync u_tick_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .async_in (AUD_CLK),
    .tick     (tick)
  );

  assign SRAM_DQ   = {SRAM_DQ_W{1'bz}};
  assign SRAM_CE_N = SRAM_CE_N_C;
  assign SRAM_WE_N = SRAM_WE_N_C;
  assign SRAM_UB_N = SRAM_UB_N_C;
  assign SRAM_LB_N = SRAM_LB_N_C;
  assign SRAM_OE_N = (state inside {ADDR, WAIT, CAPTURE}) ? SRAM_OE_ON : SRAM_OE_OFF;
  assign busy      = (state != IDLE);

  assign last_ch = (ch == CH_W'(NUM_CH - 1));
  assign at_end  = (cur_addr == end_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      cur_addr     <= '0;
      start_q      <= '0;
      end_q        <= '0;
      ch           <= '0;
      wcnt         <= '0;
      end_flag     <= 1'b0;
      stage        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      SRAM_ADDR    <= '0;
`ifdef ZERO_ON_IDLE_EN
      zero_pend    <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;

      // A tick is only consumable in WAIT_TICK; IDLE ignores it silently.
      if (tick && !(state inside {IDLE, WAIT_TICK})) overrun <= 1'b1;

`ifdef ZERO_ON_IDLE_EN
      // Silence after a natural end lands one cycle after the final frame,
      // so that frame still reaches the codec.
      if (zero_pend) begin
        sample_out   <= '0;
        sample_valid <= 1'b1;
        zero_pend    <= 1'b0;
      end
`endif

      if (stop && state != IDLE) begin
        state <= IDLE;
`ifdef ZERO_ON_IDLE_EN
        sample_out   <= '0;
        sample_valid <= 1'b1;
`endif
      end else begin
        unique case (state)
          IDLE: if (start && !stop) begin
            start_q  <= start_addr;
            end_q    <= end_addr;
            cur_addr <= start_addr;
            overrun  <= 1'b0;
            state    <= WAIT_TICK;
          end
          WAIT_TICK: if (tick) begin
            ch       <= '0;
            end_flag <= 1'b0;
            state    <= ADDR;
          end
          ADDR: begin
            SRAM_ADDR <= cur_addr;
            wcnt      <= '0;
            state     <= (WAIT_CYC == 0) ? CAPTURE : WAIT;
          end
          WAIT: begin
            if (wcnt == WAIT_CNT_W'(WAIT_CYC - 1)) state <= CAPTURE;
            else                                    wcnt  <= wcnt + WAIT_CNT_W'(1);
          end
          CAPTURE: begin
            stage[ch] <= DATA_W'(SRAM_DQ);
            if (at_end && !loop_en) begin
              // Region exhausted: pad the rest of the frame with silence
              // and commit without touching the SRAM again.
              end_flag <= 1'b1;
              for (int k = 0; k < NUM_CH; k++)
                if (k > int'(ch)) stage[k] <= '0;
              state <= COMMIT;
            end else begin
              cur_addr <= at_end ? start_q : cur_addr + ADDR_W'(1);
              if (last_ch) state <= COMMIT;
              else begin
                ch    <= ch + CH_W'(1);
                state <= ADDR;
              end
            end
          end
          COMMIT: begin
            sample_out   <= stage;
            sample_valid <= 1'b1;
            if (end_flag) begin
              done  <= 1'b1;
              state <= IDLE;
`ifdef ZERO_ON_IDLE_EN
              zero_pend <= 1'b1;
`endif
            end else begin
              state <= WAIT_TICK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_sample_streamer.sv
// Directed bench for sram_sample_streamer: three instances (defaults,
// NUM_CH=3, WAIT_CYC=3) each with its own small SRAM model.
module tb_sram_sample_streamer;

`ifdef ZERO_ON_IDLE_EN
  localparam bit ZOI = 1'b1;
`else
  localparam bit ZOI = 1'b0;
`endif

  logic        CLK = 1'b0, RESET = 1'b1, AUD_CLK = 1'b0;
  logic        stop = 1'b0, loop_en = 1'b0;
  logic        start0 = 1'b0, start3 = 1'b0, startw = 1'b0;
  logic [19:0] start_addr = '0, end_addr = 20'd3;

  wire  [15:0] dq0, dq3, dqw;
  logic [19:0] addr0, addr3, addrw;
  logic        ce0, oe0, we0, ub0, lb0;
  logic        ce3, oe3, we3, ub3, lb3;
  logic        cew, oew, wew, ubw, lbw;
  logic [31:0] so0, sow;
  logic [47:0] so3;
  logic        sv0, sv3, svw, busy0, busy3, busyw;
  logic        done0, done3, donew, ovr0, ovr3, ovrw;

  int n_chk = 0, n_err = 0, we_bad = 0;

  always #10 CLK = ~CLK;

  function automatic logic [15:0] mem_rd(input logic [19:0] a);
    case (a)
      20'd0:   return 16'h1111;
      20'd1:   return 16'h2222;
      20'd2:   return 16'h3333;
      20'd3:   return 16'h4444;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign dq0 = (oe0 == 1'b0) ? mem_rd(addr0) : 16'hzzzz;
  assign dq3 = (oe3 == 1'b0) ? mem_rd(addr3) : 16'hzzzz;
  assign dqw = (oew == 1'b0) ? mem_rd(addrw) : 16'hzzzz;

  sram_sample_streamer dut (
    .CLK(CLK), .RESET(RESET), .AUD_CLK(AUD_CLK), .start(start0), .stop(stop),
    .loop_en(loop_en), .start_addr(start_addr), .end_addr(end_addr),
    .SRAM_DQ(dq0), .SRAM_ADDR(addr0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0),
    .SRAM_WE_N(we0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0), .sample_out(so0),
    .sample_valid(sv0), .busy(busy0), .done(done0), .overrun(ovr0));

  sram_sample_streamer #(.NUM_CH(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .AUD_CLK(AUD_CLK), .start(start3), .stop(stop),
    .loop_en(loop_en), .start_addr(start_addr), .end_addr(end_addr),
    .SRAM_DQ(dq3), .SRAM_ADDR(addr3), .SRAM_CE_N(ce3), .SRAM_OE_N(oe3),
    .SRAM_WE_N(we3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .sample_out(so3),
    .sample_valid(sv3), .busy(busy3), .done(done3), .overrun(ovr3));

  sram_sample_streamer #(.WAIT_CYC(3)) dutw (
    .CLK(CLK), .RESET(RESET), .AUD_CLK(AUD_CLK), .start(startw), .stop(stop),
    .loop_en(loop_en), .start_addr(start_addr), .end_addr(end_addr),
    .SRAM_DQ(dqw), .SRAM_ADDR(addrw), .SRAM_CE_N(cew), .SRAM_OE_N(oew),
    .SRAM_WE_N(wew), .SRAM_UB_N(ubw), .SRAM_LB_N(lbw), .sample_out(sow),
    .sample_valid(svw), .busy(busyw), .done(donew), .overrun(ovrw));

  always @(negedge CLK) if (wew !== 1'b1) we_bad++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic vld_of(input int which);
    return (which == 0) ? sv0 : (which == 1) ? sv3 : svw;
  endfunction

  function automatic logic done_of(input int which);
    return (which == 0) ? done0 : (which == 1) ? done3 : donew;
  endfunction

  // Raise AUD_CLK (called just after an edge), then count edges until the
  // frame appears. Sync consumes the tick on edge 3, so the result is
  // 3 + NUM_CH*(WAIT_CYC+2) + 1. Returns -1 when no frame arrives.
  task automatic tick_wait(input int which, output int lat, output bit saw_done);
    lat = -1;
    saw_done = 1'b0;
    AUD_CLK = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 2) AUD_CLK = 1'b0;
      if (done_of(which)) saw_done = 1'b1;
      if (vld_of(which)) begin
        lat = n;
        break;
      end
    end
    AUD_CLK = 1'b0;
  endtask

  initial begin
    int lat, cnt;
    bit dn, dn_any;

    // reset state
    repeat (2) step();
    chk("rst_out", so0, 0);
    chk("rst_vld", sv0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ovr", ovr0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_oe", oe0, 1);
    chk("rst_we", we0, 1);
    chk("rst_ce", ce0, 0);
    RESET = 1'b0;
    step();

    // T1: one-shot region 0..3, two frames then done
    start0 = 1'b1; step(); start0 = 1'b0;
    chk("t1_busy", busy0, 1);
    tick_wait(0, lat, dn);
    chk("t1_lat", lat, 10);
    chk("t1_f0", so0, 32'h2222_1111);
    chk("t1_nodone0", dn, 0);
    chk("t1_oe_idle", oe0, 1);
    step();
    chk("t1_vld_pulse", sv0, 0);
    tick_wait(0, lat, dn);
    chk("t1_f1", so0, 32'h4444_3333);
    chk("t1_done", done0, 1);
    step();
    chk("t1_idle", busy0, 0);
    chk("t1_done_pulse", done0, 0);

    // T2: loop mode, third frame wraps, never done
    loop_en = 1'b1;
    start0 = 1'b1; step(); start0 = 1'b0;
    dn_any = 1'b0;
    tick_wait(0, lat, dn); dn_any |= dn;
    chk("t2_f0", so0, 32'h2222_1111);
    tick_wait(0, lat, dn); dn_any |= dn;
    chk("t2_f1", so0, 32'h4444_3333);
    tick_wait(0, lat, dn); dn_any |= dn;
    chk("t2_f2", so0, 32'h2222_1111);
    chk("t2_nodone", dn_any, 0);
    chk("t2_busy", busy0, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t2_stop_idle", busy0, 0);
    chk("t2_stop_out", so0, ZOI ? 64'h0 : 64'h2222_1111);
    loop_en = 1'b0;

    // T3: three channels, end mid-frame pads with zeros
    start3 = 1'b1; step(); start3 = 1'b0;
    tick_wait(1, lat, dn);
    chk("t3_lat", lat, 13);
    chk("t3_f0", so3, 48'h3333_2222_1111);
    tick_wait(1, lat, dn);
    chk("t3_f1", so3, 48'h0000_0000_4444);
    chk("t3_done", done3, 1);
    step();
    chk("t3_idle", busy3, 0);

    // T4: second AUD_CLK edge 3 cycles after the first
    start0 = 1'b1; step(); start0 = 1'b0;
    chk("t4_ovr_clr", ovr0, 0);
    cnt = 0;
    AUD_CLK = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 1) AUD_CLK = 1'b0;
      if (n == 3) AUD_CLK = 1'b1;
      if (n == 5) AUD_CLK = 1'b0;
      if (sv0) cnt++;
    end
    chk("t4_ovr", ovr0, 1);
    chk("t4_one_frame", cnt, 1);
    chk("t4_frame", so0, 32'h2222_1111);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_ovr_sticky", ovr0, 1);
    start0 = 1'b1; step(); start0 = 1'b0;
    chk("t4_ovr_start", ovr0, 0);

    // T5: stop during the wait state of channel 1
    AUD_CLK = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step();
      if (n == 2) AUD_CLK = 1'b0;
    end
    chk("t5_midfetch_oe", oe0, 0);
    chk("t5_midfetch_addr", addr0, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t5_idle", busy0, 0);
    chk("t5_vld", sv0, ZOI);
    chk("t5_out", so0, ZOI ? 64'h0 : 64'h2222_1111);
    chk("t5_oe", oe0, 1);
    cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (sv0) cnt++;
    end
    chk("t5_no_frame", cnt, 0);
    chk("t5_done", done0, 0);

    // T6: three wait states, then reset in the middle of a fetch
    startw = 1'b1; step(); startw = 1'b0;
    tick_wait(2, lat, dn);
    chk("t6_lat", lat, 14);
    chk("t6_f0", sow, 32'h2222_1111);
    AUD_CLK = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (n == 2) AUD_CLK = 1'b0;
    end
    chk("t6_mid_busy", busyw, 1);
    chk("t6_mid_addr", addrw, 2);
    RESET = 1'b1;
    #1;
    chk("t6_rst_out", sow, 0);
    chk("t6_rst_busy", busyw, 0);
    chk("t6_rst_vld", svw, 0);
    chk("t6_rst_addr", addrw, 0);
    chk("t6_rst_oe", oew, 1);
    chk("t6_rst_out0", so0, 0);
    step();
    RESET = 1'b0;
    step();
    chk("t6_we_const", we_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
